asmd_divider: RTL and testbench

- ASMD-style sequential restoring divider; the inverse datapath to the team's shift-add asmd_multiplier.
- Uses the same start/ready handshake and the same word_length parameter as the multiplier.
- Produces quotient and remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit; the same bench style checks multiply-then-divide round trips.

---
 rtl/asmd_divider.sv | 130 +++++++++++++
 tb/tb_asmd_divider.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/asmd_divider.sv
// rtl/asmd_divider.sv - sequential restoring divider, one quotient bit per clock, start/ready handshake
// Optional build macro ASMD_DIVIDER_EARLY_EXIT_EN: a dividend smaller than the divisor
// skips the iterations and completes in a single busy cycle with identical results.
module asmd_divider #(
  parameter int word_length = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [word_length-1:0] dividend,
  input  logic [word_length-1:0] divisor,
  input  logic                   start,
  output logic [word_length-1:0] quotient,
  output logic [word_length-1:0] remainder,
  output logic                   ready,
  output logic                   div_by_zero
);

  localparam int CW = $clog2(word_length + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_DZ
  } state_t;

  state_t state;
  state_t state_next;

  // A only ever holds a value below the divisor, so its stored width is word_length;
  // the extra bit of the shifted accumulator lives only in a_shift / trial.
  logic [word_length-1:0] a_reg;
  logic [word_length-1:0] q_reg;
  logic [word_length-1:0] d_reg;
  logic [CW-1:0]          count;

  logic [word_length:0]   a_shift;
  logic [word_length:0]   trial;

  assign a_shift = {a_reg, q_reg[word_length-1]};
  assign trial   = a_shift - {1'b0, d_reg};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake output
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (divisor == '0) begin
            state_next = S_DZ;
`ifdef ASMD_DIVIDER_EARLY_EXIT_EN
          end else if (dividend < divisor) begin
            state_next = S_DONE;
`endif
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (count == CW'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_DZ:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract/restore iterations, result publication
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // q_reg doubles as the latched dividend for the divide-by-zero result
            q_reg <= dividend;
            d_reg <= divisor;
            a_reg <= '0;
            count <= CW'(word_length);
`ifdef ASMD_DIVIDER_EARLY_EXIT_EN
            if ((divisor != '0) && (dividend < divisor)) begin
              q_reg <= '0;
              a_reg <= dividend;
            end
`endif
          end
        end
        S_RUN: begin
          // Negative trial keeps the shifted A (its top bit is zero in that case)
          a_reg <= trial[word_length] ? a_shift[word_length-1:0] : trial[word_length-1:0];
          q_reg <= {q_reg[word_length-2:0], ~trial[word_length]};
          count <= count - CW'(1);
        end
        S_DONE: begin
          quotient    <= q_reg;
          remainder   <= a_reg;
          div_by_zero <= 1'b0;
        end
        S_DZ: begin
          quotient    <= '1;
          remainder   <= q_reg;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asmd_divider.sv
// tb/tb_asmd_divider.sv - randomized self-checking bench for asmd_divider against an arithmetic model
module tb_asmd_divider;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef ASMD_DIVIDER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         start;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  asmd_divider #(.word_length(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .dividend    (dividend),
    .divisor     (divisor),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure the busy window and compare against plain arithmetic.
  task automatic run_op(input int dd, input int dv, input bit hold, input string tag);
    int n;
    int exp_q, exp_r, exp_dz, exp_busy;
    dividend = dd[W-1:0];
    divisor  = dv[W-1:0];
    start    = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      tick();
    end
    if (dv == 0) begin
      exp_q = MAXV; exp_r = dd; exp_dz = 1; exp_busy = 1;
    end else begin
      exp_q = dd / dv; exp_r = dd % dv; exp_dz = 0;
      exp_busy = (EARLY && dd < dv) ? 1 : W + 1;
    end
    check_eq({tag, ".busy"}, n, exp_busy);
    check_eq({tag, ".quotient"}, int'(quotient), exp_q);
    check_eq({tag, ".remainder"}, int'(remainder), exp_r);
    check_eq({tag, ".div_by_zero"}, int'(div_by_zero), exp_dz);
    if (dv != 0) begin
      check_eq({tag, ".identity"}, int'(quotient) * dv + int'(remainder), dd);
    end
  endtask

  initial begin
    int dd, dv, a, b;
    bit hold;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset.ready", int'(ready), 1);
    check_eq("reset.quotient", int'(quotient), 0);
    check_eq("reset.remainder", int'(remainder), 0);
    check_eq("reset.div_by_zero", int'(div_by_zero), 0);
    tick();

    run_op(13, 3, 1'b0, "basic_13_3");

    run_op(15, 1, 1'b1, "edge_15_1");
    run_op(15, 15, 1'b1, "edge_15_15");
    run_op(0, 7, 1'b0, "edge_0_7");

    run_op(7, 0, 1'b0, "dz_7_0");
    run_op(9, 2, 1'b0, "after_dz_9_2");

    run_op(2, 9, 1'b0, "small_2_9");

    // Reset mid-operation with an ignored start in between
    dividend = 4'd14; divisor = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("midrst.busy1", int'(ready), 0);
    tick();
    dividend = 4'd9; divisor = 4'd3; start = 1'b1;
    tick();
    check_eq("midrst.ignored_start", int'(ready), 0);
    start = 1'b0; reset = 1'b1;
    tick();
    check_eq("midrst.ready", int'(ready), 1);
    check_eq("midrst.quotient", int'(quotient), 0);
    check_eq("midrst.remainder", int'(remainder), 0);
    check_eq("midrst.div_by_zero", int'(div_by_zero), 0);
    reset = 1'b0;
    for (int i = 0; i < W + 3; i++) tick();
    check_eq("midrst.no_result_q", int'(quotient), 0);
    check_eq("midrst.no_result_r", int'(remainder), 0);
    check_eq("midrst.still_ready", int'(ready), 1);

    // Multiply-then-divide round trips
    for (int i = 0; i < 20; i++) begin
      b = $urandom_range(1, MAXV);
      a = $urandom_range(0, MAXV / b);
      run_op(a * b, b, 1'b0, "roundtrip");
      check_eq("roundtrip.recover", int'(quotient), a);
    end

    // Random traffic, occasionally zero divisors and held start
    for (int i = 0; i < 150; i++) begin
      dd = $urandom_range(0, MAXV);
      dv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAXV);
      hold = (i != 149) && ($urandom_range(0, 1) == 1);
      run_op(dd, dv, hold, "random");
    end
    start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
